// File: rtl/sync_debounce_pkg.sv
// rtl/sync_debounce_pkg.sv - shared state encoding and parameter limits for sync_debounce
package sync_debounce_pkg;

    typedef logic [1:0] state_t;

    // Bit 1 of the state is the debounced level and bit 0 marks qualification.
    localparam state_t ST_LO     = 2'd0;
    localparam state_t ST_CHK_HI = 2'd1;
    localparam state_t ST_HI     = 2'd2;
    localparam state_t ST_CHK_LO = 2'd3;

    localparam int MIN_SYNC_STAGES     = 2;
    localparam int MIN_DEBOUNCE_CYCLES = 1;

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - N-stage flop synchronizer with synchronous active-low reset to 0
module sync_chain #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] stage_q;
    logic [N-1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[N-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[N-1];

endmodule

// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - synchronizer plus debounce FSM with rise/fall pulses; EDGE_CNT_EN adds edge_cnt
module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    output logic             q,
    output logic             rise,
    output logic             fall,
    output logic             busy
`ifdef EDGE_CNT_EN
    ,
    output logic [CNT_W-1:0] edge_cnt
`endif
);

    localparam int CNT_BITS = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("sync_debounce: SYNC_STAGES below minimum");
    end
    if (DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES) begin : g_bad_deb
        $error("sync_debounce: DEBOUNCE_CYCLES below minimum");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("sync_debounce: CNT_W must be at least 1");
    end

    logic s;

    sync_chain #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (din),
        .q     (s)
    );

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LO: begin
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = ST_HI;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = ST_CHK_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_CHK_HI: begin
                if (!s) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HI;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HI: begin
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = ST_LO;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = ST_CHK_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            default: begin
                if (s) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LO;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_LO;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign q    = state_q[1];
    assign busy = state_q[0];
    assign rise = rise_q;
    assign fall = fall_q;

`ifdef EDGE_CNT_EN
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;

    // Counts on rise_d so the count updates on the same edge rise goes high.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (rise_d) begin
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// tb/tb_sync_debounce.sv - directed self-checking bench for sync_debounce
module tb_sync_debounce;
    import sync_debounce_pkg::*;

    logic clk;
    logic rst_n;
    logic din;
    logic q, rise, fall, busy;
    logic din1;
    logic q1, rise1, fall1, busy1;
`ifdef EDGE_CNT_EN
    logic [1:0] edge_cnt;
    logic [1:0] edge_cnt1;
`endif

    int checks;
    int failures;

    sync_debounce #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .q        (q),
        .rise     (rise),
        .fall     (fall),
        .busy     (busy)
`ifdef EDGE_CNT_EN
        ,
        .edge_cnt (edge_cnt)
`endif
    );

    sync_debounce #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (1),
        .CNT_W           (2)
    ) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din1),
        .q        (q1),
        .rise     (rise1),
        .fall     (fall1),
        .busy     (busy1)
`ifdef EDGE_CNT_EN
        ,
        .edge_cnt (edge_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        din   = 1'b1;
        din1  = 1'b0;
        rst_n = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if ({q, rise, fall, busy} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_hold cycle %0d: q/rise/fall/busy=%b required 0000", c, {q, rise, fall, busy});
            end
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if ({q, rise, fall} !== {(e >= 6) ? 1'b1 : 1'b0, (e == 6) ? 1'b1 : 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL reset_release edge %0d: q/rise/fall=%b%b%b required %b%b0",
                         e, q, rise, fall, (e >= 6), (e == 6));
            end
        end
    endtask

    task automatic test_fall();
        din = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if ({q, rise, fall, busy} !== {(e < 6) ? 1'b1 : 1'b0, 1'b0, (e == 6) ? 1'b1 : 1'b0,
                                           (e >= 3 && e <= 5) ? 1'b1 : 1'b0}) begin
                failures++;
                $display("FAIL fall edge %0d: q/rise/fall/busy=%b%b%b%b required %b0%b%b",
                         e, q, rise, fall, busy, (e < 6), (e == 6), (e >= 3 && e <= 5));
            end
        end
    endtask

    task automatic test_rise();
        din = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if ({q, rise, fall, busy} !== {(e >= 6) ? 1'b1 : 1'b0, (e == 6) ? 1'b1 : 1'b0, 1'b0,
                                           (e >= 3 && e <= 5) ? 1'b1 : 1'b0}) begin
                failures++;
                $display("FAIL rise edge %0d: q/rise/fall/busy=%b%b%b%b required %b%b0%b",
                         e, q, rise, fall, busy, (e >= 6), (e == 6), (e >= 3 && e <= 5));
            end
        end
    endtask

    task automatic test_glitch();
        for (int e = 1; e <= 10; e++) begin
            din = (e <= 3) ? 1'b1 : 1'b0;
            tick();
            checks++;
            if ({q, rise, fall, busy} !== {1'b0, 1'b0, 1'b0, (e >= 3 && e <= 5) ? 1'b1 : 1'b0}) begin
                failures++;
                $display("FAIL glitch edge %0d: q/rise/fall/busy=%b%b%b%b required 000%b",
                         e, q, rise, fall, busy, (e >= 3 && e <= 5));
            end
        end
        checks++;
        if (dut.state_q !== ST_LO) begin
            failures++;
            $display("FAIL glitch_state: state=%0d required %0d", dut.state_q, ST_LO);
        end
    endtask

    task automatic test_reset_mid();
        din = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({q, rise, fall, busy} !== 4'b0000 || dut.state_q !== ST_LO) begin
            failures++;
            $display("FAIL reset_mid_abort: q/rise/fall/busy=%b state=%0d required 0000 state 0",
                     {q, rise, fall, busy}, dut.state_q);
        end
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if ({q, rise} !== {(e >= 6) ? 1'b1 : 1'b0, (e == 6) ? 1'b1 : 1'b0}) begin
                failures++;
                $display("FAIL reset_mid_resume edge %0d: q/rise=%b%b required %b%b",
                         e, q, rise, (e >= 6), (e == 6));
            end
        end
        din = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
        end
    endtask

`ifdef EDGE_CNT_EN
    task automatic test_edge_cnt();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        din   = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (edge_cnt !== 2'd0) begin
            failures++;
            $display("FAIL edge_cnt_reset: edge_cnt=%0d required 0", edge_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            din = 1'b1;
            for (int e = 1; e <= 7; e++) begin
                tick();
                if (e == 6) begin
                    checks++;
                    if (rise !== 1'b1 || edge_cnt !== exp_cnt[i]) begin
                        failures++;
                        $display("FAIL edge_cnt pulse %0d: rise=%b edge_cnt=%0d required rise=1 edge_cnt=%0d",
                                 i, rise, edge_cnt, exp_cnt[i]);
                    end
                end
            end
            din = 1'b0;
            for (int e = 1; e <= 7; e++) begin
                tick();
            end
        end
    endtask
`endif

    task automatic test_d1();
        logic [7:0] pat;
        logic       exp_q, prev_q;
        pat    = 8'b0100_1101;
        prev_q = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            din1 = (k <= 8) ? pat[k-1] : 1'b0;
            tick();
            exp_q = (k >= 3) ? pat[k-3] : 1'b0;
            checks++;
            if ({q1, rise1, fall1, busy1} !== {exp_q, exp_q & ~prev_q, ~exp_q & prev_q, 1'b0}) begin
                failures++;
                $display("FAIL d1 edge %0d: q/rise/fall/busy=%b%b%b%b required %b%b%b0",
                         k, q1, rise1, fall1, busy1, exp_q, exp_q & ~prev_q, ~exp_q & prev_q);
            end
            prev_q = exp_q;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        din      = 1'b0;
        din1     = 1'b0;
        test_reset();
        test_fall();
        test_rise();
        test_fall();
        for (int e = 0; e < 4; e++) tick();
        test_glitch();
        test_reset_mid();
`ifdef EDGE_CNT_EN
        test_edge_cnt();
`endif
        test_d1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
